// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder: element defaults, FP16 zero, FSM encoding.
package systolic_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } feeder_state_t;

    // Zero-flush length so the last vector reaches the far corner PE of an n x n array.
    function automatic int drain_len(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/skew_delay.sv
// Plain per-lane shift register used to stagger the array edge feeds; DEPTH=0 is a wire.
module skew_delay #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_shift
            logic [DATA_WIDTH-1:0] sr_r [DEPTH];

            // Shift chain; cleared by reset so no stale data leaks into a new job.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < DEPTH; s++) sr_r[s] <= {DATA_WIDTH{1'b0}};
                end else begin
                    sr_r[0] <= d;
                    for (int s = 1; s < DEPTH; s++) sr_r[s] <= sr_r[s-1];
                end
            end

            assign q = sr_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Skewed west/north edge feeder for an N x N output-stationary systolic array.
// Optional FEEDER_BUBBLE_CNT_EN adds a saturating count of STREAM cycles without input data.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N          = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              cfg_k,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_a_col,
    input  logic [N*DATA_WIDTH-1:0] in_b_row,
    output logic [N*DATA_WIDTH-1:0] a_out,
    output logic [N*DATA_WIDTH-1:0] b_out,
    output logic                    array_reset_n,
`ifdef FEEDER_BUBBLE_CNT_EN
    output logic [15:0]             bubble_count,
`endif
    output logic                    busy,
    output logic                    done
);

    localparam int DRAIN_LEN = drain_len(N);
    localparam int DCW       = $clog2(DRAIN_LEN + 1);

    feeder_state_t state_r, state_s;
    logic [7:0]     k_r, k_cnt_r;
    logic [DCW-1:0] drain_cnt_r;
    logic           in_ready_r, busy_r, done_r, array_reset_n_r;
    logic           accept_s, last_s;
    logic [N*DATA_WIDTH-1:0] a_stage_r, b_stage_r;

    assign accept_s = in_ready_r & in_valid;
    assign last_s   = accept_s & (k_cnt_r == (k_r - 8'd1));

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_CLEAR;
                else       state_s = ST_IDLE;
            end
            ST_CLEAR: begin
                if (k_r != 8'd0) state_s = ST_STREAM;
                else             state_s = ST_DONE;
            end
            ST_STREAM: begin
                if (last_s) state_s = ST_DRAIN;
                else        state_s = ST_STREAM;
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DCW'(DRAIN_LEN - 1)) state_s = ST_DONE;
                else                                    state_s = ST_DRAIN;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, job counters and registered status outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            k_r             <= 8'd0;
            k_cnt_r         <= 8'd0;
            drain_cnt_r     <= {DCW{1'b0}};
            in_ready_r      <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            array_reset_n_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_IDLE && start) k_r <= cfg_k;
            if (state_r == ST_CLEAR)  k_cnt_r <= 8'd0;
            else if (accept_s)        k_cnt_r <= k_cnt_r + 8'd1;
            if (state_r == ST_DRAIN)  drain_cnt_r <= drain_cnt_r + {{(DCW-1){1'b0}}, 1'b1};
            else                      drain_cnt_r <= {DCW{1'b0}};
            in_ready_r      <= (state_s == ST_STREAM);
            busy_r          <= (state_s != ST_IDLE);
            done_r          <= (state_s == ST_DONE);
            array_reset_n_r <= (state_s != ST_CLEAR);
        end
    end

    // Skew input stage: accepted data, otherwise FP16 zero so zeros trail the last vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_stage_r <= {N{FP16_ZERO}};
            b_stage_r <= {N{FP16_ZERO}};
        end else if (accept_s) begin
            a_stage_r <= in_a_col;
            b_stage_r <= in_b_row;
        end else begin
            a_stage_r <= {N{FP16_ZERO}};
            b_stage_r <= {N{FP16_ZERO}};
        end
    end

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_lane
            skew_delay #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_skew_a (
                .clk   (clk),
                .reset (reset),
                .d     (a_stage_r[i*DATA_WIDTH +: DATA_WIDTH]),
                .q     (a_out[i*DATA_WIDTH +: DATA_WIDTH])
            );
            skew_delay #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_skew_b (
                .clk   (clk),
                .reset (reset),
                .d     (b_stage_r[i*DATA_WIDTH +: DATA_WIDTH]),
                .q     (b_out[i*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0] bubble_r;

    // Saturating count of STREAM cycles that had to inject a zero vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_r <= 16'd0;
        end else if (state_r == ST_CLEAR) begin
            bubble_r <= 16'd0;
        end else if (state_r == ST_STREAM && !in_valid && bubble_r != 16'hFFFF) begin
            bubble_r <= bubble_r + 16'd1;
        end else begin
            bubble_r <= bubble_r;
        end
    end

    assign bubble_count = bubble_r;
`endif

    assign in_ready      = in_ready_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign array_reset_n = array_reset_n_r;

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, FP16 element width.
REQ-002 Parameter N, default 4, array dimension (rows = columns).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a matrix job.
REQ-006 cfg_k  input  8  inner dimension K; sampled when start is accepted.
REQ-007 in_valid  input  1  in_a_col/in_b_row carry one K-step vector pair.
REQ-008 in_ready  output  1  feeder accepts a vector this cycle.
REQ-009 in_a_col  input  N*DATA_WIDTH  A[i][k] in lane i (lane 0 = LSBs).
REQ-010 in_b_row  input  N*DATA_WIDTH  B[k][j] in lane j.
REQ-011 a_out  output  N*DATA_WIDTH  skewed west-edge feed; lane i goes to array row i.
REQ-012 b_out  output  N*DATA_WIDTH  skewed north-edge feed; lane j goes to array column j.
REQ-013 array_reset_n  output  1  active-low clear for the PE accumulators.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse; PE_out values are final.

Function
REQ-016 FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-017 IDLE->CLEAR when start=1; cfg_k is latched on the same edge.
REQ-018 In CLEAR, array_reset_n=0 for exactly one cycle.
- Next state is STREAM if latched K>0.
- Next state is DONE if K=0; no data is streamed.
REQ-019 In STREAM, in_ready=1; in all other states in_ready=0.
REQ-020 Accepted vector = cycle with in_valid & in_ready; a K-step counter increments per accepted vector.
REQ-021 In a STREAM cycle with in_valid=0, an all-zero vector (FP16 +0.0) is injected; the K counter does not advance.
REQ-022 STREAM->DRAIN on the edge accepting vector K; that vector is the last one accepted.
REQ-023 DRAIN injects zero vectors for exactly 2*N cycles, then goes to DONE.
REQ-024 DONE asserts done=1 for one cycle, then returns to IDLE.
REQ-025 Skew: vector entering the skew stage at edge t appears on a_out lane i and b_out lane i at cycle t+1+i.
- Lane 0 has 1 registered cycle.
- Lane i has i additional register stages.
REQ-026 Outside STREAM, the skew stage input is zero, so zeros shift through after the last data.
REQ-027 start is ignored while busy=1.
REQ-028 No arithmetic on data; values pass bit-exact.

Reset
REQ-029 Reset=1 at any clock edge, including mid-job:
- State forced to IDLE.
- All skew registers and counters cleared.
- a_out=0, b_out=0, in_ready=0, busy=0, done=0.
- array_reset_n=0 while reset=1, returning to 1 the cycle after reset deasserts.
REQ-030 A job interrupted by reset is abandoned; no done pulse is generated for it.

Configuration
REQ-031 FEEDER_BUBBLE_CNT_EN defined:
- Extra output bubble_count, 16 bits.
- Counts STREAM cycles with in_valid=0; saturates at 0xFFFF.
- Cleared in CLEAR and on reset.
REQ-032 FEEDER_BUBBLE_CNT_EN undefined:
- No bubble_count port and no counter logic.
- All other behaviour identical.

Structure
REQ-033 Package systolic_pkg holds:
- DATA_WIDTH default.
- FP16_ZERO constant (16'h0000).
- Feeder state enum typedef.
- DRAIN length function (2*N).
REQ-034 Sub-module skew_delay (parameters DEPTH, DATA_WIDTH; a plain shift register).
- Instantiated once per lane with DEPTH = lane index.
- DEPTH=0 degenerates to a wire.

Verification
REQ-035 N=4, K=1, start then in_valid with A lanes 3C00,4000,4200,4400:
- a_out lane0=3C00 at t+1, lane1=4000 at t+2, lane2=4200 at t+3, lane3=4400 at t+4.
- done pulses 8 DRAIN cycles after DRAIN entry.
REQ-036 K=3 with in_valid low on the 2nd STREAM cycle:
- One zero vector is injected; STREAM lasts 4 cycles.
- bubble_count=1 when the macro is defined.
REQ-037 cfg_k=0:
- IDLE->CLEAR->DONE; done one cycle after CLEAR.
- a_out/b_out stay 0 throughout.
REQ-038 Reset asserted mid-STREAM:
- Next cycle busy=0, a_out=b_out=0.
- No done pulse follows; a new start works normally.
REQ-039 start pulsed while busy:
- Ignored; cfg_k is not relatched.
- Exactly one done pulse for the original job.
REQ-040 End-to-end with a 4x4 systolic array, A=I, B=all 3C00 (1.0), K=4:
- Every PE_out reads 3C00 at done.
